// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480@60 timing constants, lock FSM states, helpers.
// Used by vga_driver and vga_timing_decoder.
package vga_pkg;

   localparam int H_DISP  = 640;
   localparam int H_FP    = 16;
   localparam int H_PULSE = 96;
   localparam int H_BP    = 48;
   localparam int H_TOTAL = H_DISP + H_FP + H_PULSE + H_BP;

   localparam int V_DISP  = 480;
   localparam int V_FP    = 10;
   localparam int V_PULSE = 2;
   localparam int V_BP    = 33;
   localparam int V_TOTAL = V_DISP + V_FP + V_PULSE + V_BP;

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2
   } lock_state_t;

   function automatic logic [9:0] sat_inc10(input logic [9:0] v);
      return (&v) ? v : v + 10'd1;
   endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// vga_sync_edge: registers one sync input, normalises polarity, flags lead edge.
// Ports: clk, rst_n, sync (raw) -> lead (one-cycle pulse on active edge).
module vga_sync_edge #(
   parameter bit POL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sync,
   output logic lead
);

   logic act_q;
   logic act_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_q <= 1'b0;
         act_d <= 1'b0;
      end else begin
         act_q <= (sync == POL);
         act_d <= act_q;
      end
   end

   assign lead = act_q & ~act_d;

endmodule

// File: rtl/vga_timing_decoder.sv
// vga_timing_decoder: recovers x/y from hsync/vsync/video, measures periods, locks.
// Ports: i_clk/i_rstn, i_hsync/i_vsync/i_video in; o_x/o_y/o_de/starts, totals, lock, err.
module vga_timing_decoder #(
   parameter int H_DISP      = vga_pkg::H_DISP,
   parameter int H_TOTAL     = vga_pkg::H_TOTAL,
   parameter int V_DISP      = vga_pkg::V_DISP,
   parameter int V_TOTAL     = vga_pkg::V_TOTAL,
   parameter bit HS_POL      = 1'b0,
   parameter bit VS_POL      = 1'b0,
   parameter int LOCK_FRAMES = 2,
   parameter int CNT_W       = 11
) (
   input  logic             i_clk,
   input  logic             i_rstn,
   input  logic             i_hsync,
   input  logic             i_vsync,
   input  logic             i_video,
   output logic [9:0]       o_x,
   output logic [9:0]       o_y,
   output logic             o_de,
   output logic             o_line_start,
   output logic             o_frame_start,
   output logic [CNT_W-1:0] o_h_total,
   output logic [CNT_W-1:0] o_v_total,
   output logic             o_locked,
   output logic             o_err
);

   import vga_pkg::*;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             hs_lead;
   logic             vs_lead;
   logic             vid_q;
   logic             de_q;
   logic             de_rise;
   logic             de_fall;
   logic [9:0]       x_cnt;
   logic [9:0]       y_cnt;
   logic [9:0]       de_len;
   logic [CNT_W-1:0] h_per;
   logic [CNT_W-1:0] h_cap;
   logic [CNT_W-1:0] ln_cnt;
   logic             h_sat;
   logic             sat_evt;
   logic             h_bad;
   logic             x_bad;
   logic             v_bad;
   logic             y_bad;
   logic             line_bad;
   logic             frame_ok;

   lock_state_t      state;
   lock_state_t      state_nx;
   logic [7:0]       good;
   logic [7:0]       good_nx;
   logic             err_nx;

   vga_sync_edge #(.POL(HS_POL)) u_hs (
      .clk   (i_clk),
      .rst_n (i_rstn),
      .sync  (i_hsync),
      .lead  (hs_lead)
   );

   vga_sync_edge #(.POL(VS_POL)) u_vs (
      .clk   (i_clk),
      .rst_n (i_rstn),
      .sync  (i_vsync),
      .lead  (vs_lead)
   );

   assign de_rise = vid_q & ~de_q;
   assign de_fall = ~vid_q & de_q;
   assign h_sat   = (h_per == CNT_MAX);
   assign h_cap   = h_sat ? CNT_MAX : h_per + CNT_W'(1);
   assign sat_evt = h_sat & ~hs_lead;
   assign h_bad   = hs_lead & (h_cap != CNT_W'(H_TOTAL));
   assign x_bad   = de_fall & (x_cnt != 10'(H_DISP));
   assign v_bad   = vs_lead & (ln_cnt != CNT_W'(V_TOTAL));
   assign y_bad   = (y_cnt > 10'(V_DISP));

   // The hsync edge coinciding with vsync closes the last line of the frame.
   assign frame_ok = (ln_cnt == CNT_W'(V_TOTAL)) & ~line_bad & ~h_bad
                   & (de_len == 10'(H_DISP));

   assign o_de     = de_q;
   assign o_locked = (state == LOCKED);

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         vid_q         <= 1'b0;
         de_q          <= 1'b0;
         x_cnt         <= '0;
         y_cnt         <= '0;
         de_len        <= '0;
         h_per         <= '0;
         ln_cnt        <= '0;
         line_bad      <= 1'b0;
         o_x           <= '0;
         o_y           <= '0;
         o_line_start  <= 1'b0;
         o_frame_start <= 1'b0;
         o_h_total     <= '0;
         o_v_total     <= '0;
         o_err         <= 1'b0;
      end else begin
         vid_q <= i_video;
         de_q  <= vid_q;

         x_cnt <= vid_q ? sat_inc10(x_cnt) : 10'd0;
         if (de_fall) de_len <= x_cnt;

         if (vs_lead)      y_cnt <= '0;
         else if (de_fall) y_cnt <= sat_inc10(y_cnt);

         if (hs_lead) begin
            o_h_total <= h_cap;
            h_per     <= '0;
         end else if (!h_sat) begin
            h_per <= h_per + CNT_W'(1);
         end

         if (vs_lead) begin
            o_v_total <= ln_cnt;
            ln_cnt    <= hs_lead ? CNT_W'(1) : '0;
         end else if (hs_lead && ln_cnt != CNT_MAX) begin
            ln_cnt <= ln_cnt + CNT_W'(1);
         end

         if (vs_lead)    line_bad <= 1'b0;
         else if (h_bad) line_bad <= 1'b1;

         o_x           <= vid_q ? x_cnt : 10'd0;
         o_y           <= y_cnt;
         o_line_start  <= de_rise;
         o_frame_start <= de_rise & (y_cnt == 10'd0);
         o_err         <= err_nx;
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state <= SEARCH;
         good  <= '0;
      end else begin
         state <= state_nx;
         good  <= good_nx;
      end
   end

   always_comb begin
      state_nx = state;
      good_nx  = good;
      err_nx   = 1'b0;
      unique case (state)
         SEARCH: begin
            // First capture after search is partial, so only arm here.
            if (vs_lead) begin
               state_nx = ACQUIRE;
               good_nx  = '0;
            end
         end
         ACQUIRE: begin
            if (sat_evt) begin
               state_nx = SEARCH;
               good_nx  = '0;
            end else if (vs_lead) begin
               if (frame_ok) begin
                  good_nx = good + 8'd1;
                  if (good_nx >= 8'(LOCK_FRAMES)) state_nx = LOCKED;
               end else begin
                  good_nx = '0;
               end
            end
         end
         LOCKED: begin
            if (h_bad | x_bad | v_bad | y_bad | sat_evt) begin
               err_nx   = 1'b1;
               state_nx = SEARCH;
               good_nx  = '0;
            end
         end
         default: begin
            state_nx = SEARCH;
            good_nx  = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_vga_timing_decoder.sv
// tb_vga_timing_decoder: reduced-size timing source driving the decoder,
// pixel scoreboard plus directed lock/error/reset checks.
module tb_vga_timing_decoder;

   localparam int HD  = 16;
   localparam int HT  = 40;
   localparam int HSS = 20;
   localparam int HSW = 6;
   localparam int VD  = 8;
   localparam int VT  = 12;
   localparam int VSS = 9;
   localparam int VSW = 2;
   localparam int CW  = 11;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          hsync = 1'b1;
   logic          vsync = 1'b1;
   logic          video = 1'b0;
   logic [9:0]    o_x;
   logic [9:0]    o_y;
   logic          o_de;
   logic          ls;
   logic          fs;
   logic [CW-1:0] ht;
   logic [CW-1:0] vt;
   logic          lk;
   logic          er;

   vga_timing_decoder #(
      .H_DISP      (HD),
      .H_TOTAL     (HT),
      .V_DISP      (VD),
      .V_TOTAL     (VT),
      .HS_POL      (1'b0),
      .VS_POL      (1'b0),
      .LOCK_FRAMES (2),
      .CNT_W       (CW)
   ) dut (
      .i_clk         (clk),
      .i_rstn        (rst_n),
      .i_hsync       (hsync),
      .i_vsync       (vsync),
      .i_video       (video),
      .o_x           (o_x),
      .o_y           (o_y),
      .o_de          (o_de),
      .o_line_start  (ls),
      .o_frame_start (fs),
      .o_h_total     (ht),
      .o_v_total     (vt),
      .o_locked      (lk),
      .o_err         (er)
   );

   always #20 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int c;
      int x;
      int y;
      bit ls;
      bit fs;
   } exp_t;

   exp_t q[$];
   int   tests   = 0;
   int   fails   = 0;
   int   err_cnt = 0;
   int   err_cyc = 0;
   int   last_hs = 0;
   int   vs_h    = 0;
   int   e0;
   bit   sb_en   = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_line(input int v, input int len);
      exp_t e;
      for (int h = 0; h < len; h++) begin
         @(posedge clk);
         #1;
         video = (v < VD) && (h < HD);
         hsync = !((h >= HSS) && (h < HSS + HSW));
         if (h == HSS) last_hs = cyc;
         vsync = !(((v > VSS) || (v == VSS && h >= vs_h)) &&
                   ((v < VSS + VSW) || (v == VSS + VSW && h < vs_h)));
         if (video && sb_en) begin
            e.c  = cyc + 2;
            e.x  = h;
            e.y  = v;
            e.ls = (h == 0);
            e.fs = (h == 0) && (v == 0);
            q.push_back(e);
         end
      end
   endtask

   task automatic frame(input int short_line);
      for (int v = 0; v < VT; v++)
         drive_line(v, (v == short_line) ? HT - 1 : HT);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         hsync = 1'b1;
         vsync = 1'b1;
         video = 1'b0;
      end
   endtask

   initial begin
      fork
         forever begin : mon
            exp_t e;
            @(negedge clk);
            if (rst_n) begin
               if (er) begin
                  err_cnt++;
                  err_cyc = cyc;
               end
               if (o_de) begin
                  if (q.size() > 0) begin
                     e = q.pop_front();
                     check("pix", 64'({32'(cyc), o_x, o_y, ls, fs}),
                           64'({32'(e.c), 10'(e.x), 10'(e.y), e.ls, e.fs}));
                  end else if (sb_en) begin
                     check("de_unexpected", 64'(o_de), 64'd0);
                  end
               end else if (sb_en) begin
                  check("blank", 64'({o_x, ls, fs}), 64'd0);
               end
            end
         end
      join_none

      repeat (3) @(posedge clk);
      #1;
      check("rst_x", 64'(o_x), 64'd0);
      check("rst_y", 64'(o_y), 64'd0);
      check("rst_de", 64'({o_de, ls, fs, er}), 64'd0);
      check("rst_tot", 64'({ht, vt}), 64'd0);
      check("rst_lock", 64'(lk), 64'd0);
      rst_n = 1'b1;
      sb_en = 1'b1;

      frame(-1);
      check("lock_vs1", 64'(lk), 64'd0);
      frame(-1);
      check("lock_vs2", 64'(lk), 64'd0);
      frame(-1);
      check("lock_vs3", 64'(lk), 64'd1);
      check("h_total", 64'(ht), 64'(HT));
      check("v_total", 64'(vt), 64'(VT));
      check("no_err_lock", 64'(err_cnt), 64'd0);

      e0 = err_cnt;
      frame(4);
      check("short_err", 64'(err_cnt), 64'(e0 + 1));
      check("short_unlock", 64'(lk), 64'd0);
      frame(-1);
      check("short_relock1", 64'(lk), 64'd0);
      frame(-1);
      check("short_relock2", 64'(lk), 64'd1);
      check("short_err_once", 64'(err_cnt), 64'(e0 + 1));

      e0 = err_cnt;
      vs_h = HSS;
      frame(-1);
      frame(-1);
      check("same_v_total", 64'(vt), 64'(VT));
      check("same_lock", 64'(lk), 64'd1);
      vs_h = 0;
      frame(-1);
      check("same_back_vt", 64'(vt), 64'(VT));
      check("same_back_lock", 64'(lk), 64'd1);
      check("same_no_err", 64'(err_cnt), 64'(e0));

      e0 = err_cnt;
      idle(2100);
      check("sat_err", 64'(err_cnt), 64'(e0 + 1));
      check("sat_err_cyc", 64'(err_cyc), 64'(last_hs + 2050));
      check("sat_unlock", 64'(lk), 64'd0);
      frame(-1);
      frame(-1);
      check("sat_relock1", 64'(lk), 64'd0);
      frame(-1);
      check("sat_relock2", 64'(lk), 64'd1);

      for (int v = 0; v < 3; v++) drive_line(v, HT);
      rst_n = 1'b0;
      sb_en = 1'b0;
      #2;
      check("mid_rst_x", 64'({o_x, o_y}), 64'd0);
      check("mid_rst_flags", 64'({o_de, ls, fs, er, lk}), 64'd0);
      check("mid_rst_tot", 64'({ht, vt}), 64'd0);
      q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int v = 3; v < VT; v++) drive_line(v, HT);
      check("rst_relock_vs1", 64'(lk), 64'd0);
      sb_en = 1'b1;
      frame(-1);
      check("rst_relock_vs2", 64'(lk), 64'd0);
      frame(-1);
      check("rst_relock_vs3", 64'(lk), 64'd1);

      idle(5);
      check("sb_drain", 64'(q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
